// File: rtl/proc_hier_core.sv
// Single-cycle 16-bit processor top level with instruction/data memories and a per-cycle trace port.
// Optional cycle counter: define PROC_HIER_CYCLE_COUNT_EN.
module proc_hier_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_we,
  input  logic        load_sel,
  input  logic [7:0]  load_addr,
  input  logic [15:0] load_data,
  output logic [15:0] pc,
  output logic [15:0] inst,
  output logic        reg_write,
  output logic [2:0]  write_reg,
  output logic [15:0] write_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        halt,
  output logic [31:0] cycle_count
);

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_SUBI  = 5'b01001;
  localparam logic [4:0] OP_XORI  = 5'b01010;
  localparam logic [4:0] OP_ANDNI = 5'b01011;
  localparam logic [4:0] OP_BEQZ  = 5'b01100;
  localparam logic [4:0] OP_BNEZ  = 5'b01101;
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_STU   = 5'b10011;
  localparam logic [4:0] OP_LBI   = 5'b11000;
  localparam logic [4:0] OP_RTYPE = 5'b11011;

  logic [15:0] pcReg;
  logic        halted;
  logic [15:0] regFile [8];
  logic [15:0] imem [256];
  logic [15:0] dmem [256];

  logic [15:0] instWord;
  logic [4:0]  opcode;
  logic [2:0]  rsIdx, rtIdx, rdIdx;
  logic [15:0] rsVal, rtVal, effAddr, pcPlus2, nextPc;
  logic signed [15:0] imm5S, imm8S, disp11S;
  logic [15:0] imm5Z;

  logic        regWe, memRd, memWe, isHalt;
  logic [2:0]  wReg;
  logic [15:0] wData, mAddr, mData;

  assign instWord = imem[pcReg[8:1]];
  assign opcode   = instWord[15:11];
  assign rsIdx    = instWord[10:8];
  assign rtIdx    = instWord[7:5];
  assign rdIdx    = instWord[4:2];
  assign imm5S    = {{11{instWord[4]}}, instWord[4:0]};
  assign imm8S    = {{8{instWord[7]}}, instWord[7:0]};
  assign disp11S  = {{5{instWord[10]}}, instWord[10:0]};
  assign imm5Z    = {11'b0, instWord[4:0]};
  assign rsVal    = regFile[rsIdx];
  assign rtVal    = regFile[rtIdx];
  assign effAddr  = rsVal + imm5S;
  assign pcPlus2  = pcReg + 16'd2;

  always_comb begin
    regWe  = 1'b0;
    memRd  = 1'b0;
    memWe  = 1'b0;
    isHalt = 1'b0;
    wReg   = '0;
    wData  = '0;
    mAddr  = '0;
    mData  = '0;
    nextPc = pcPlus2;
    case (opcode)
      OP_HALT: begin
        isHalt = 1'b1;
        nextPc = pcReg;
      end
      OP_ADDI:  begin regWe = 1'b1; wReg = rtIdx; wData = rsVal + imm5S; end
      OP_SUBI:  begin regWe = 1'b1; wReg = rtIdx; wData = imm5S - rsVal; end
      OP_XORI:  begin regWe = 1'b1; wReg = rtIdx; wData = rsVal ^ imm5Z; end
      OP_ANDNI: begin regWe = 1'b1; wReg = rtIdx; wData = rsVal & ~imm5Z; end
      OP_RTYPE: begin
        regWe = 1'b1;
        wReg  = rdIdx;
        case (instWord[1:0])
          2'b00:   wData = rsVal + rtVal;
          2'b01:   wData = rtVal - rsVal;
          2'b10:   wData = rsVal ^ rtVal;
          default: wData = rsVal & ~rtVal;
        endcase
      end
      OP_LBI: begin regWe = 1'b1; wReg = rsIdx; wData = imm8S; end
      OP_ST: begin
        memWe = 1'b1;
        mAddr = effAddr;
        mData = rtVal;
      end
      OP_LD: begin
        memRd = 1'b1;
        mAddr = effAddr;
        regWe = 1'b1;
        wReg  = rtIdx;
        wData = dmem[effAddr[8:1]];
      end
      // Store-with-update: memory takes the old R[rt], R[rs] takes the effective address.
      OP_STU: begin
        memWe = 1'b1;
        mAddr = effAddr;
        mData = rtVal;
        regWe = 1'b1;
        wReg  = rsIdx;
        wData = effAddr;
      end
      OP_BEQZ: if (rsVal == 16'd0) nextPc = pcPlus2 + imm8S;
      OP_BNEZ: if (rsVal != 16'd0) nextPc = pcPlus2 + imm8S;
      OP_J:    nextPc = pcPlus2 + disp11S;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pcReg  <= '0;
      halted <= 1'b0;
    end else if (!halted) begin
      pcReg <= nextPc;
      if (isHalt) halted <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) regFile[i] <= '0;
    end else if (regWe && !halted) begin
      regFile[wReg] <= wData;
    end
  end

  // Memories are never cleared; the load port is only live while reset is held.
  always_ff @(posedge clk) begin
    if (!rst && load_we && !load_sel) imem[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (load_we && load_sel) dmem[load_addr] <= load_data;
    end else if (memWe && !halted) begin
      dmem[mAddr[8:1]] <= mData;
    end
  end

`ifdef PROC_HIER_CYCLE_COUNT_EN
  logic [31:0] cycleCnt;
  always_ff @(posedge clk) begin
    if (!rst) cycleCnt <= '0;
    else      cycleCnt <= cycleCnt + 32'd1;
  end
  assign cycle_count = cycleCnt;
`else
  assign cycle_count = '0;
`endif

  assign pc         = pcReg;
  assign inst       = instWord;
  assign reg_write  = regWe;
  assign write_reg  = wReg;
  assign write_data = wData;
  assign mem_read   = memRd;
  assign mem_write  = memWe;
  assign mem_addr   = mAddr;
  assign mem_data   = mData;
  assign halt       = isHalt;

endmodule

// File: tb/tb_proc_hier_core.sv
// Scoreboard bench for proc_hier_core: an architectural model predicts the trace of every
// retired instruction; a negedge monitor pops and compares.
module tb_proc_hier_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_we;
  logic        load_sel;
  logic [7:0]  load_addr;
  logic [15:0] load_data;
  logic [15:0] pc, inst, write_data, mem_addr, mem_data;
  logic        reg_write, mem_read, mem_write, halt;
  logic [2:0]  write_reg;
  logic [31:0] cycle_count;

  proc_hier_core dut (
    .clk(clk), .rst(rst), .load_we(load_we), .load_sel(load_sel),
    .load_addr(load_addr), .load_data(load_data),
    .pc(pc), .inst(inst), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_data(mem_data), .halt(halt),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] inst;
    logic        rw;
    logic [2:0]  wr;
    logic [15:0] wd;
    logic        mr;
    logic        mw;
    logic [15:0] ma;
    logic [15:0] md;
    logic        hlt;
    logic [31:0] cc;
  } trace_t;

  trace_t expQ[$];
  trace_t seenQ[$];
  int total = 0;
  int bad = 0;
  int recIdx = 0;

  // Architectural model state
  logic [15:0] mReg [8];
  logic [15:0] mImem [256];
  logic [15:0] mDmem [256];
  logic [15:0] mPc;
  logic [15:0] progImg [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    trace_t act, exp;
    if (rst === 1'b1) begin
      act = '{pc, inst, reg_write, write_reg, write_data, mem_read, mem_write,
              mem_addr, mem_data, halt, cycle_count};
      seenQ.push_back(act);
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("FAIL trace[%0d] unexpected: got %h want none", recIdx, act);
      end else begin
        exp = expQ.pop_front();
        if (act !== exp) begin
          bad++;
          $display("FAIL trace[%0d]: got %h want %h", recIdx, act, exp);
        end
      end
      recIdx++;
    end
  end

  function automatic logic [15:0] sx(input int v, input int bits);
    int r = v;
    if (r >= (1 << (bits - 1))) r -= (1 << bits);
    return 16'(r);
  endfunction

  function automatic logic [31:0] ccExp(input int k);
`ifdef PROC_HIER_CYCLE_COUNT_EN
    return 32'(k);
`else
    return 32'd0 + 32'(k - k);
`endif
  endfunction

  // Executes one instruction on the model and returns its trace.
  task automatic modelStep(input int k, output trace_t t);
    logic [15:0] ins, a, b, npc, i5, i8, i11, z5;
    t = '0;
    ins = mImem[mPc[8:1]];
    t.pc = mPc;
    t.inst = ins;
    t.cc = ccExp(k);
    a = mReg[ins[10:8]];
    b = mReg[ins[7:5]];
    i5 = sx(int'(ins[4:0]), 5);
    i8 = sx(int'(ins[7:0]), 8);
    i11 = sx(int'(ins[10:0]), 11);
    z5 = 16'(ins[4:0]);
    npc = mPc + 16'd2;
    case (ins[15:11])
      5'b00000: begin t.hlt = 1'b1; npc = mPc; end
      5'b01000: begin t.rw = 1; t.wr = ins[7:5]; t.wd = a + i5; end
      5'b01001: begin t.rw = 1; t.wr = ins[7:5]; t.wd = i5 - a; end
      5'b01010: begin t.rw = 1; t.wr = ins[7:5]; t.wd = a ^ z5; end
      5'b01011: begin t.rw = 1; t.wr = ins[7:5]; t.wd = a & ~z5; end
      5'b11011: begin
        t.rw = 1; t.wr = ins[4:2];
        if (ins[1:0] == 2'd0) t.wd = a + b;
        else if (ins[1:0] == 2'd1) t.wd = b - a;
        else if (ins[1:0] == 2'd2) t.wd = a ^ b;
        else t.wd = a & ~b;
      end
      5'b11000: begin t.rw = 1; t.wr = ins[10:8]; t.wd = i8; end
      5'b10000: begin t.mw = 1; t.ma = a + i5; t.md = b; end
      5'b10001: begin
        t.mr = 1; t.ma = a + i5; t.rw = 1; t.wr = ins[7:5];
        t.wd = mDmem[t.ma[8:1]];
      end
      5'b10011: begin
        t.mw = 1; t.ma = a + i5; t.md = b;
        t.rw = 1; t.wr = ins[10:8]; t.wd = t.ma;
      end
      5'b01100: if (a == 0) npc = mPc + 16'd2 + i8;
      5'b01101: if (a != 0) npc = mPc + 16'd2 + i8;
      5'b00100: npc = mPc + 16'd2 + i11;
      default: ;
    endcase
    if (t.mw) mDmem[t.ma[8:1]] = t.md;
    if (t.rw) mReg[t.wr] = t.wd;
    mPc = npc;
  endtask

  task automatic loadWord(input logic sel, input int idx, input logic [15:0] val);
    load_we = 1'b1;
    load_sel = sel;
    load_addr = 8'(idx);
    load_data = val;
    if (sel) mDmem[idx] = val;
    else mImem[idx] = val;
    @(posedge clk); #1;
    load_we = 1'b0;
  endtask

  task automatic loadProg();
    for (int i = 0; i < 256; i++) loadWord(1'b0, i, progImg[i]);
  endtask

  task automatic loadRandData();
    for (int i = 0; i < 256; i++) loadWord(1'b1, i, 16'($urandom));
  endtask

  task automatic fillNop();
    for (int i = 0; i < 256; i++) progImg[i] = 16'h0800;
  endtask

  function automatic logic [15:0] randInst();
    logic [4:0] ops [14];
    ops = '{5'b00001, 5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b11011, 5'b11000,
            5'b10000, 5'b10001, 5'b10011, 5'b01100, 5'b01101, 5'b00100, 5'b11111};
    if ($urandom_range(0, 99) < 2) return 16'h0000;
    return {ops[$urandom_range(0, 13)], 11'($urandom)};
  endfunction

  // Predict n instructions, run them with rst released (load port driven but ignored),
  // then assert reset so instruction n is aborted.
  task automatic runProg(input int n);
    trace_t t;
    mPc = '0;
    for (int r = 0; r < 8; r++) mReg[r] = '0;
    for (int k = 0; k < n; k++) begin
      modelStep(k, t);
      expQ.push_back(t);
    end
    seenQ.delete();
    recIdx = 0;
    rst = 1'b1;
    repeat (n) begin
      load_we = 1'($urandom);
      load_sel = 1'($urandom);
      load_addr = 8'($urandom);
      load_data = 16'($urandom);
      @(posedge clk); #1;
    end
    load_we = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("drain", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    load_we = 1'b0;
    load_sel = 1'b0;
    load_addr = '0;
    load_data = '0;
    repeat (2) @(posedge clk);
    #1;

    // Directed: arithmetic, memory, branches, halt
    fillNop();
    progImg[0]  = 16'hC105;  // LBI R1,#5
    progImg[1]  = 16'h415F;  // ADDI R2,R1,#-1
    progImg[2]  = 16'hD94D;  // SUB R3 = R2-R1
    progImg[3]  = 16'hC110;  // LBI R1,#0x10
    progImg[4]  = 16'h8142;  // ST R2 -> [R1+2]
    progImg[5]  = 16'h8982;  // LD R4 <- [R1+2]
    progImg[6]  = 16'hC120;  // LBI R1,#0x20
    progImg[7]  = 16'h9944;  // STU R2 -> [R1+4]
    progImg[8]  = 16'h6004;  // BEQZ R0,+4
    progImg[11] = 16'h6804;  // BNEZ R0,+4
    progImg[12] = 16'h0000;  // HALT
    loadProg();
    loadRandData();
    runProg(14);
    chk("lbi_pc", 32'(seenQ[0].pc), 32'h0);
    chk("lbi_wr", {seenQ[0].rw, 28'(seenQ[0].wr)}, {1'b1, 28'd1});
    chk("lbi_wd", 32'(seenQ[0].wd), 32'h0005);
    chk("reset_cc", seenQ[0].cc, 32'd0);
    chk("addi_pc", 32'(seenQ[1].pc), 32'h0002);
    chk("addi_wd", {12'(seenQ[1].wr), 4'd0, seenQ[1].wd}, {12'd2, 4'd0, 16'h0004});
    chk("sub_wd", 32'(seenQ[2].wd), 32'h0000FFFF);
    chk("st", {seenQ[4].mw, 15'(seenQ[4].ma), seenQ[4].md}, {1'b1, 15'h0012, 16'h0004});
    chk("ld", {seenQ[5].mr, 15'd0, seenQ[5].wd}, {1'b1, 15'd0, 16'h0004});
    chk("stu_mem", {seenQ[7].mw, 15'(seenQ[7].ma)}, {1'b1, 15'h0024});
    chk("stu_reg", {seenQ[7].rw, 12'(seenQ[7].wr), 3'd0, seenQ[7].wd}, {1'b1, 12'd1, 3'd0, 16'h0024});
    chk("beqz_taken", 32'(seenQ[9].pc), 32'h0016);
    chk("bnez_nottaken", 32'(seenQ[10].pc), 32'h0018);
    chk("halt_hold", {seenQ[13].hlt, 15'(seenQ[13].rw), seenQ[13].pc}, {1'b1, 15'd0, 16'h0018});
    chk("halt_cc", seenQ[13].cc, ccExp(13));

    // Directed: HALT at 0x000A, then restart from reset
    fillNop();
    progImg[5] = 16'h0000;
    loadProg();
    runProg(10);
    chk("halt_a_pc", {15'(seenQ[9].hlt), seenQ[9].pc}, {15'd1, 16'h000A});

    // Directed: J -4 from 0 wraps to 0xFFFE, NOP there wraps PC to 0
    fillNop();
    progImg[0] = 16'h27FC;
    loadProg();
    runProg(6);
    chk("restart_pc", 32'(seenQ[0].pc), 32'h0);
    chk("restart_cc", seenQ[0].cc, 32'd0);
    chk("wrap_fffe", 32'(seenQ[1].pc), 32'h0000FFFE);
    chk("wrap_0", 32'(seenQ[2].pc), 32'h0);

    // Directed: J -2 loops onto itself
    fillNop();
    progImg[1] = 16'h27FE;
    loadProg();
    runProg(6);
    chk("jself", 32'(seenQ[5].pc), 32'h0002);

    // Randomized programs; data memory reloaded only on some runs so aborted/ignored
    // writes carried across resets are visible.
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < 256; i++) progImg[i] = randInst();
      loadProg();
      if (p % 2 == 0) loadRandData();
      runProg(120 + int'($urandom_range(0, 60)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
